kernel_rot: RTL and testbench
=============================

# kernel_rot

Runtime-sized neighbourhood generator for the imager pixel stream. Sits in the same pipeline slot as the fixed-size kernel stage but selects the active window size per frame (2..KERNEL_SIZE) and uses pointer-rotated row buffers instead of shifting data between buffers. Emits a KERNEL_SIZE x KERNEL_SIZE array with the active window right/bottom-aligned and unused entries zeroed. Crops (k-1) rows/cols and rewrites the header image size to match.

## Interface
- KERNEL_SIZE, 5, maximum window size; KERNEL_SIZE-1 row buffers are instantiated
- PIXEL_WIDTH, 10, pixel bits taken from datai[PIXEL_WIDTH-1:0]
- DATA_WIDTH, 16, stream/meta word width
- MAX_COLS, 1288, row buffer depth
- NUM_COLS_WIDTH, 11, column address width
- KSEL_WIDTH, 3, width of ksize
- clk  in  1  clock; resetb  in  1  reset. Reset resetb, asynchronous, active-low; clock clk.
- enable  in  1  0 = passthrough, 1 = kernel mode
- ksize  in  KSEL_WIDTH  requested window size, sampled at FRAME_START
- dvi  in  1  input data valid
- dtypei  in  `DTYPE_WIDTH  input data type
- datai  in  DATA_WIDTH  input word
- dvo  out  1  output valid
- dtypeo  out  `DTYPE_WIDTH  dtypei delayed 1 cycle
- meta_datao  out  DATA_WIDTH  datai delayed 1 cycle, header-adjusted
- kernel_datao  out  KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH  packed window, entry [r][c] at ((r*KERNEL_SIZE)+c)*PIXEL_WIDTH
- row_len_err  out  1  sticky row-length mismatch flag (see Configuration)

## Operation
- Active size k_act: latched from ksize on dvi && FRAME_START && enable; clamped: <2 -> 2, >KERNEL_SIZE -> KERNEL_SIZE. Mid-frame ksize changes ignored.
- Row buffers: async-read, sync-write, read-before-write at same address. All share col_addr; only buffer wp written (we = dvi && pixel type && enable).
- Write pointer wp: 0 at FRAME_START; at ROW_END, wp <= (wp == k_act-2) ? 0 : wp+1.
- Window on each pixel: all entries shift left one column; new right column: row KERNEL_SIZE-1 <- datai; row KERNEL_SIZE-1-j <- buffer (wp-j) mod (k_act-1) for j=1..k_act-2; row KERNEL_SIZE-k_act <- buffer wp (oldest). Rows < KERNEL_SIZE-k_act and cols < KERNEL_SIZE-k_act forced to 0.
- col_addr: 0 at ROW_START, +1 per pixel. row_addr: 0 at FRAME_START, +1 per ROW_END, saturates at KERNEL_SIZE-1.
- valid_col = col_addr >= k_act-1; valid_row = row_addr >= k_act-1.
- dvo (when dvi, enable): FRAME_START/other non-pixel -> 1; ROW_START, ROW_END -> valid_row; pixel -> valid_row && valid_col. dvi=0 -> dvo 0.
- enable=0: dvo <= dvi; row_addr, col_addr, wp cleared; window held; meta_datao = datai.
- Header: header_addr (6 bits) cleared on HEADER_START, +1 per HEADER word. When enable && dvi && header_addr is `Image_num_cols or `Image_num_rows: meta_datao <= datai - (k_act-1); else datai.

## Timing
- All outputs registered; latency 1 cycle from dvi/dtypei/datai to dvo/dtypeo/meta_datao/kernel_datao.
- Reset values: dvo 0, dtypeo 0, meta_datao 0, kernel_datao all 0, row_len_err 0; internal wp 0, k_act KERNEL_SIZE, counters 0.
- FRAME_START and header words in the same frame use the newly latched k_act starting the cycle after FRAME_START.
- ROW_END with wp at k_act-2 wraps to 0 same edge; first pixel of next row reads rotated order.
- Reset mid-frame: all state cleared; output resumes correctly from next FRAME_START.
- col_addr wrap beyond MAX_COLS is undefined; upstream guarantees rows <= MAX_COLS.

## Configuration
- KERNEL_ROW_CHECK_EN defined: first completed row's pixel count stored as ref; any later ROW_END with col_addr != ref sets row_len_err; cleared at FRAME_START. Only active with enable=1.
- Undefined: no reference counter logic; row_len_err tied 0.

## Test plan
- 6x6 ramp image (pixel = 8*row+col), ksize=3, KERNEL_SIZE=5 -> 4 valid rows x 4 valid pixels; first dvo pixel window rows 2..4 = {0,1,2},{8,9,10},{16,17,18}; rows 0..1, cols 0..1 zero.
- Same image ksize=5 -> 2x2 output pixels; first window = full 5x5 ramp starting at 0; header num_cols 6 -> 2, num_rows 6 -> 2.
- ksize=0 and ksize=7 -> behave as k=2 and k=5 respectively (output 5x5 and 2x2 for 6x6 input).
- ksize changed 3->5 mid-frame -> current frame stays k=3; next frame uses k=5.
- enable=0 stream -> dvo mirrors dvi one cycle late, meta_datao = datai, header unmodified.
- With KERNEL_ROW_CHECK_EN, rows of 6,6,5 pixels -> row_len_err rises after third ROW_END, clears at next FRAME_START; without macro stays 0.

Source files
------------

// File: rtl/kernel_rot.sv
// kernel_rot: runtime-sized (2..KERNEL_SIZE) neighbourhood generator using pointer-rotated row buffers.
// Define KERNEL_ROW_CHECK_EN to build the sticky row-length mismatch flag; otherwise row_len_err is tied 0.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef FRAME_START
`define FRAME_START 4'd0
`endif
`ifndef FRAME_END
`define FRAME_END 4'd1
`endif
`ifndef ROW_START
`define ROW_START 4'd2
`endif
`ifndef ROW_END
`define ROW_END 4'd3
`endif
`ifndef PIXEL
`define PIXEL 4'd4
`endif
`ifndef HEADER_START
`define HEADER_START 4'd5
`endif
`ifndef HEADER
`define HEADER 4'd6
`endif
`ifndef HEADER_END
`define HEADER_END 4'd7
`endif
`ifndef Image_num_cols
`define Image_num_cols 6'd2
`endif
`ifndef Image_num_rows
`define Image_num_rows 6'd3
`endif

module kernel_rot #(
   parameter int KERNEL_SIZE    = 5,
   parameter int PIXEL_WIDTH    = 10,
   parameter int DATA_WIDTH     = 16,
   parameter int MAX_COLS       = 1288,
   parameter int NUM_COLS_WIDTH = 11,
   parameter int KSEL_WIDTH     = 3
) (
   input  logic                                              clk,
   input  logic                                              resetb,
   input  logic                                              enable,
   input  logic [KSEL_WIDTH-1:0]                             ksize,
   input  logic                                              dvi,
   input  logic [`DTYPE_WIDTH-1:0]                           dtypei,
   input  logic [DATA_WIDTH-1:0]                             datai,
   output logic                                              dvo,
   output logic [`DTYPE_WIDTH-1:0]                           dtypeo,
   output logic [DATA_WIDTH-1:0]                             meta_datao,
   output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0]    kernel_datao,
   output logic                                              row_len_err
);

   localparam int KW = $clog2(KERNEL_SIZE + 1);
   localparam int PW = (KERNEL_SIZE > 2) ? $clog2(KERNEL_SIZE - 1) : 1;

   typedef logic [PIXEL_WIDTH-1:0] pix_t;

   pix_t rowBuf [KERNEL_SIZE-1][MAX_COLS];
   pix_t bufRd  [KERNEL_SIZE-1];
   pix_t newCol [KERNEL_SIZE];
   pix_t win_q  [KERNEL_SIZE][KERNEL_SIZE];
   pix_t win_d  [KERNEL_SIZE][KERNEL_SIZE];

   logic [KW-1:0]                kAct_q, kAct_d, kClamp;
   logic [PW-1:0]                wp_q, wp_d;
   logic [KW-1:0]                rowAddr_q, rowAddr_d;
   logic [NUM_COLS_WIDTH-1:0]    colAddr_q, colAddr_d;
   logic [5:0]                   headerAddr_q, headerAddr_d;
   logic                         dvo_q, dvo_d;
   logic [`DTYPE_WIDTH-1:0]      dtypeo_q, dtypeo_d;
   logic [DATA_WIDTH-1:0]        meta_q, meta_d;
   int                           kActInt;
   logic                         validRow, validCol, isPixel, bufWe;

   assign kActInt  = int'(kAct_q);
   assign validRow = int'(rowAddr_q) >= kActInt - 1;
   assign validCol = int'(colAddr_q) >= kActInt - 1;
   assign isPixel  = (dtypei == `PIXEL);
   assign bufWe    = dvi && isPixel && enable;

   always_comb begin
      kClamp = KW'(KERNEL_SIZE);
      if (int'(ksize) < 2) begin
         kClamp = KW'(2);
      end else if (int'(ksize) <= KERNEL_SIZE) begin
         kClamp = KW'(int'(ksize));
      end
   end

   // Only the buffer under the write pointer takes the incoming row; reads see the old contents.
   always_ff @(posedge clk) begin
      if (bufWe) begin
         rowBuf[wp_q][colAddr_q] <= datai[PIXEL_WIDTH-1:0];
      end
   end

   always_comb begin
      for (int b = 0; b < KERNEL_SIZE - 1; b++) begin
         bufRd[b] = rowBuf[b][colAddr_q];
      end
   end

   // Newest row sits at the bottom; buffer (wp - j) mod (k-1) feeds the row j above it.
   always_comb begin
      int j;
      int t;
      j = 0;
      t = 0;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         newCol[r] = '0;
      end
      newCol[KERNEL_SIZE-1] = datai[PIXEL_WIDTH-1:0];
      for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
         j = KERNEL_SIZE - 1 - r;
         if (j <= kActInt - 1) begin
            t = int'(wp_q) + kActInt - 1 - j;
            if (t >= kActInt - 1) begin
               t = t - (kActInt - 1);
            end
            newCol[r] = bufRd[PW'(t)];
         end
      end
   end

   always_comb begin
      win_d = win_q;
      if (enable && dvi && isPixel) begin
         for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
               if (r < KERNEL_SIZE - kActInt || c < KERNEL_SIZE - kActInt) begin
                  win_d[r][c] = '0;
               end else if (c < KERNEL_SIZE - 1) begin
                  win_d[r][c] = win_q[r][c+1];
               end else begin
                  win_d[r][c] = newCol[r];
               end
            end
         end
      end
   end

   always_comb begin
      kAct_d       = kAct_q;
      wp_d         = wp_q;
      rowAddr_d    = rowAddr_q;
      colAddr_d    = colAddr_q;
      headerAddr_d = headerAddr_q;
      dvo_d        = 1'b0;
      dtypeo_d     = dtypei;
      meta_d       = datai;
      if (dvi) begin
         if (dtypei == `HEADER_START) begin
            headerAddr_d = '0;
         end else if (dtypei == `HEADER) begin
            headerAddr_d = headerAddr_q + 6'd1;
         end
      end
      if (!enable) begin
         wp_d      = '0;
         rowAddr_d = '0;
         colAddr_d = '0;
         dvo_d     = dvi;
      end else if (dvi) begin
         dvo_d = 1'b1;
         case (dtypei)
            `FRAME_START: begin
               kAct_d    = kClamp;
               wp_d      = '0;
               rowAddr_d = '0;
               colAddr_d = '0;
            end
            `ROW_START: begin
               colAddr_d = '0;
               dvo_d     = validRow;
            end
            `ROW_END: begin
               dvo_d = validRow;
               wp_d  = (wp_q == PW'(kActInt - 2)) ? '0 : wp_q + PW'(1);
               if (rowAddr_q != KW'(KERNEL_SIZE - 1)) begin
                  rowAddr_d = rowAddr_q + KW'(1);
               end
            end
            `PIXEL: begin
               dvo_d     = validRow && validCol;
               colAddr_d = colAddr_q + NUM_COLS_WIDTH'(1);
            end
            default: ;
         endcase
         // Cropping k-1 rows/cols shrinks the image; the header has to advertise the new size.
         if (dtypei == `HEADER &&
             (headerAddr_q == `Image_num_cols || headerAddr_q == `Image_num_rows)) begin
            meta_d = datai - DATA_WIDTH'(kActInt - 1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         kAct_q       <= KW'(KERNEL_SIZE);
         wp_q         <= '0;
         rowAddr_q    <= '0;
         colAddr_q    <= '0;
         headerAddr_q <= '0;
         dvo_q        <= 1'b0;
         dtypeo_q     <= '0;
         meta_q       <= '0;
         for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         kAct_q       <= kAct_d;
         wp_q         <= wp_d;
         rowAddr_q    <= rowAddr_d;
         colAddr_q    <= colAddr_d;
         headerAddr_q <= headerAddr_d;
         dvo_q        <= dvo_d;
         dtypeo_q     <= dtypeo_d;
         meta_q       <= meta_d;
         win_q        <= win_d;
      end
   end

   assign dvo        = dvo_q;
   assign dtypeo     = dtypeo_q;
   assign meta_datao = meta_q;

   always_comb begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         for (int c = 0; c < KERNEL_SIZE; c++) begin
            kernel_datao[((r*KERNEL_SIZE)+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_q[r][c];
         end
      end
   end

`ifdef KERNEL_ROW_CHECK_EN
   logic [NUM_COLS_WIDTH-1:0] refLen_q, refLen_d;
   logic                      refValid_q, refValid_d;
   logic                      rowErr_q, rowErr_d;

   // The first finished row of each frame defines the expected length for the rest.
   always_comb begin
      refLen_d   = refLen_q;
      refValid_d = refValid_q;
      rowErr_d   = rowErr_q;
      if (enable && dvi) begin
         if (dtypei == `FRAME_START) begin
            refValid_d = 1'b0;
            rowErr_d   = 1'b0;
         end else if (dtypei == `ROW_END) begin
            if (!refValid_q) begin
               refLen_d   = colAddr_q;
               refValid_d = 1'b1;
            end else if (colAddr_q != refLen_q) begin
               rowErr_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         refLen_q   <= '0;
         refValid_q <= 1'b0;
         rowErr_q   <= 1'b0;
      end else begin
         refLen_q   <= refLen_d;
         refValid_q <= refValid_d;
         rowErr_q   <= rowErr_d;
      end
   end

   assign row_len_err = rowErr_q;
`else
   assign row_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_rot.sv
// Directed bench for kernel_rot: 6x6 ramp frames at several window sizes, passthrough, resets, row-length flag.
module tb_kernel_rot;

   localparam int KK  = 5;
   localparam int PXW = 10;
   localparam int DW  = 16;
   localparam int KDW = KK*KK*PXW;

   localparam logic [3:0] DT_FS  = 4'd0;
   localparam logic [3:0] DT_FE  = 4'd1;
   localparam logic [3:0] DT_RS  = 4'd2;
   localparam logic [3:0] DT_RE  = 4'd3;
   localparam logic [3:0] DT_PIX = 4'd4;
   localparam logic [3:0] DT_HS  = 4'd5;
   localparam logic [3:0] DT_HDR = 4'd6;
   localparam logic [3:0] DT_HE  = 4'd7;

`ifdef KERNEL_ROW_CHECK_EN
   localparam logic ROWCHK = 1'b1;
`else
   localparam logic ROWCHK = 1'b0;
`endif

   logic            clk;
   logic            resetb;
   logic            enable;
   logic [2:0]      ksize;
   logic            dvi;
   logic [3:0]      dtypei;
   logic [DW-1:0]   datai;
   logic            dvo;
   logic [3:0]      dtypeo;
   logic [DW-1:0]   meta_datao;
   logic [KDW-1:0]  kernel_datao;
   logic            row_len_err;

   int total = 0;
   int bad   = 0;

   kernel_rot dut (
      .clk          (clk),
      .resetb       (resetb),
      .enable       (enable),
      .ksize        (ksize),
      .dvi          (dvi),
      .dtypei       (dtypei),
      .datai        (datai),
      .dvo          (dvo),
      .dtypeo       (dtypeo),
      .meta_datao   (meta_datao),
      .kernel_datao (kernel_datao),
      .row_len_err  (row_len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One word per cycle; outputs are examined 1 ns after the edge that registers it.
   task automatic applyStimulus(input logic v, input logic [3:0] dt, input logic [DW-1:0] d);
      @(negedge clk);
      dvi    = v;
      dtypei = dt;
      datai  = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [KDW-1:0] expWin(input int row, input int col, input int k);
      logic [KDW-1:0] w;
      w = '0;
      for (int r = 0; r < KK; r++) begin
         for (int c = 0; c < KK; c++) begin
            if (r >= KK - k && c >= KK - k) begin
               w[((r*KK)+c)*PXW +: PXW] = PXW'(8*(row - (KK-1-r)) + (col - (KK-1-c)));
            end
         end
      end
      return w;
   endfunction

   task automatic runFrame(input int kReq, input int midK, input int expK);
      int nValid;
      logic [DW-1:0] hv;
      logic vexp;
      nValid = 0;
      ksize = 3'(kReq);
      applyStimulus(1'b1, DT_FS, '0);
      checkOutput("fs_dvo", 256'(dvo), 256'(1));
      ksize = 3'(midK);
      applyStimulus(1'b1, DT_HS, '0);
      checkOutput("hs_dvo", 256'(dvo), 256'(1));
      for (int a = 0; a < 4; a++) begin
         hv = (a == 2 || a == 3) ? DW'(6) : DW'(16'h100 + a);
         applyStimulus(1'b1, DT_HDR, hv);
         checkOutput("hdr_meta", 256'(meta_datao),
                     256'((a == 2 || a == 3) ? DW'(6 - (expK - 1)) : hv));
      end
      applyStimulus(1'b1, DT_HE, '0);
      for (int row = 0; row < 6; row++) begin
         applyStimulus(1'b1, DT_RS, '0);
         checkOutput("rs_dvo", 256'(dvo), 256'(row >= expK - 1));
         for (int col = 0; col < 6; col++) begin
            applyStimulus(1'b1, DT_PIX, DW'(8*row + col));
            vexp = (row >= expK - 1) && (col >= expK - 1);
            checkOutput("pix_dvo", 256'(dvo), 256'(vexp));
            checkOutput("pix_dtype", 256'(dtypeo), 256'(DT_PIX));
            if (dvo) nValid++;
            if (vexp) checkOutput("window", 256'(kernel_datao), 256'(expWin(row, col, expK)));
         end
         applyStimulus(1'b1, DT_RE, '0);
         checkOutput("re_dvo", 256'(dvo), 256'(row >= expK - 1));
      end
      applyStimulus(1'b1, DT_FE, '0);
      checkOutput("fe_dvo", 256'(dvo), 256'(1));
      checkOutput("valid_count", 256'(nValid), 256'((7 - expK) * (7 - expK)));
   endtask

   initial begin
      resetb = 1'b0;
      enable = 1'b1;
      ksize  = 3'd3;
      dvi    = 1'b0;
      dtypei = DT_PIX;
      datai  = 16'h3ff;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_dvo",    256'(dvo),          256'(0));
      checkOutput("rst_dtype",  256'(dtypeo),       256'(0));
      checkOutput("rst_meta",   256'(meta_datao),   256'(0));
      checkOutput("rst_kernel", 256'(kernel_datao), 256'(0));
      checkOutput("rst_err",    256'(row_len_err),  256'(0));
      @(negedge clk);
      resetb = 1'b1;

      $display("[TB] k=3 frame");
      runFrame(3, 3, 3);
      $display("[TB] k=5 frame");
      runFrame(5, 5, 5);
      $display("[TB] ksize=0 clamps to 2");
      runFrame(0, 0, 2);
      $display("[TB] ksize=7 clamps to 5");
      runFrame(7, 7, 5);

      $display("[TB] passthrough");
      enable = 1'b0;
      applyStimulus(1'b1, DT_FS, 16'h0);
      checkOutput("pt_fs_dvo", 256'(dvo), 256'(1));
      applyStimulus(1'b1, DT_HS, 16'h0);
      applyStimulus(1'b1, DT_HDR, 16'h100);
      applyStimulus(1'b1, DT_HDR, 16'h101);
      applyStimulus(1'b1, DT_HDR, 16'd6);
      checkOutput("pt_hdr_meta", 256'(meta_datao), 256'(16'd6));
      applyStimulus(1'b1, DT_HDR, 16'd6);
      checkOutput("pt_hdr_meta2", 256'(meta_datao), 256'(16'd6));
      applyStimulus(1'b1, DT_RS, 16'h0);
      checkOutput("pt_rs_dvo", 256'(dvo), 256'(1));
      applyStimulus(1'b1, DT_PIX, 16'h2a5);
      checkOutput("pt_pix_dvo", 256'(dvo), 256'(1));
      checkOutput("pt_pix_meta", 256'(meta_datao), 256'(16'h2a5));
      checkOutput("pt_window_held", 256'(kernel_datao), 256'(expWin(5, 5, 5)));
      applyStimulus(1'b0, DT_PIX, 16'h11);
      checkOutput("pt_idle_dvo", 256'(dvo), 256'(0));
      applyStimulus(1'b1, DT_FE, 16'h0);
      checkOutput("pt_fe_dvo", 256'(dvo), 256'(1));
      enable = 1'b1;
      applyStimulus(1'b0, DT_PIX, 16'h0);
      checkOutput("idle_dvo", 256'(dvo), 256'(0));

      $display("[TB] ksize change mid-frame");
      runFrame(3, 5, 3);
      runFrame(5, 5, 5);

      $display("[TB] reset mid-frame");
      ksize = 3'd5;
      applyStimulus(1'b1, DT_FS, 16'h0);
      applyStimulus(1'b1, DT_RS, 16'h0);
      for (int col = 0; col < 4; col++) applyStimulus(1'b1, DT_PIX, 16'(col + 40));
      @(negedge clk);
      dvi    = 1'b0;
      resetb = 1'b0;
      #1;
      checkOutput("midrst_dvo",    256'(dvo),          256'(0));
      checkOutput("midrst_meta",   256'(meta_datao),   256'(0));
      checkOutput("midrst_kernel", 256'(kernel_datao), 256'(0));
      @(negedge clk);
      resetb = 1'b1;
      runFrame(2, 2, 2);

      $display("[TB] row length check");
      ksize = 3'd3;
      applyStimulus(1'b1, DT_FS, 16'h0);
      for (int row = 0; row < 3; row++) begin
         applyStimulus(1'b1, DT_RS, 16'h0);
         for (int col = 0; col < ((row == 2) ? 5 : 6); col++) begin
            applyStimulus(1'b1, DT_PIX, 16'(8*row + col));
         end
         applyStimulus(1'b1, DT_RE, 16'h0);
         if (row == 1) checkOutput("rowlen_ok", 256'(row_len_err), 256'(0));
      end
      checkOutput("rowlen_err", 256'(row_len_err), 256'(ROWCHK));
      applyStimulus(1'b1, DT_FE, 16'h0);
      checkOutput("rowlen_sticky", 256'(row_len_err), 256'(ROWCHK));
      applyStimulus(1'b1, DT_FS, 16'h0);
      checkOutput("rowlen_clear", 256'(row_len_err), 256'(0));
      applyStimulus(1'b1, DT_FE, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
